vector_seq_ctrl: RTL
====================

Name: vector_seq_ctrl

Overview:
- CFU command sequencer for the vector unit.
- Accepts one CFU command at a time through a valid/ready handshake, holds the vector length (vl), and issues vl per-element strobes to the vector datapath.
- Waits a fixed datapath latency, then returns a single CFU response.
- Sits between the CFU bus and the function-id decoder/register-file/ALU datapath.

Parameters:
- MAX_VL, 16: maximum vector length; vl is clamped to this value.
- IDX_W, 4: element index width; must satisfy 2**IDX_W >= MAX_VL.
- DP_LAT, 2: datapath pipeline depth in cycles; must be >= 1.

Ports:
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  CFU command valid
- cmd_ready  out  1  CFU command ready
- cmd_payload_function_id  in  10  [2:0] funct, [7:3] vd
- cmd_payload_inputs_0  in  32  vsetvli length / vs1 in [4:0] / imm in [7:0]
- cmd_payload_inputs_1  in  32  vs2 in [4:0]
- rsp_valid  out  1  CFU response valid
- rsp_ready  in  1  CFU response accept
- rsp_payload_outputs_0  out  32  response data
- dp_funct  out  3  latched funct
- dp_vd  out  5  latched vd
- dp_vs1  out  5  latched vs1
- dp_vs2  out  5  latched vs2
- dp_imm  out  8  latched imm
- dp_elem_valid  out  1  one element issued this cycle
- dp_elem_idx  out  IDX_W  element index
- dp_last  out  1  current element is vl-1
- dp_result  in  32  datapath result (accumulator/lane data)
- vl  out  IDX_W+1  current vector length

Behaviour:
- Reset values: state IDLE, so cmd_ready=1 while reset_n is low.
  - rsp_valid=0, rsp_payload_outputs_0=0, vl=0.
  - dp_elem_valid=0, dp_last=0, dp_elem_idx=0, all latched dp_* fields=0.
- States: IDLE, ISSUE, DRAIN, RESP.
  - cmd_ready=1 only in IDLE.
  - rsp_valid=1 only in RESP.
- IDLE: on cmd_valid, latch funct/vd/vs1/vs2/imm.
  - funct=0 (vsetvli): vl <= min(inputs_0, MAX_VL) with full 32-bit compare; response = new vl; go to RESP.
  - funct 1..5 with vl=0: response=0; go to RESP; no dp_elem_valid.
  - funct 1..5 with vl>0: dp_elem_idx <= 0; go to ISSUE.
  - funct 6 or 7: response=32'hFFFF_FFFF; go to RESP; no datapath activity.
- ISSUE: dp_elem_valid=1 every cycle; dp_elem_idx increments by 1 per cycle.
  - When dp_elem_idx==vl-1: dp_last=1; load the drain counter with DP_LAT; go to DRAIN.
- DRAIN: counter decrements each cycle; state lasts exactly DP_LAT cycles.
  - On the final DRAIN edge, capture dp_result into the response register; go to RESP.
- RESP: rsp_valid and the response are held stable until rsp_ready=1; then go to IDLE.
  - rsp_ready already high on entry gives a one-cycle RESP.
- Latency (accept edge = cycle 0):
  - ISSUE occupies cycles 1..vl; DRAIN occupies vl+1..vl+DP_LAT; rsp_valid first rises in cycle vl+DP_LAT+1.
  - vsetvli, vl=0 and illegal commands: rsp_valid in cycle 1.
- Back-to-back: the next command is accepted no earlier than the cycle after the response handshake.
- vl changes only on an accepted vsetvli. vl is never modified while ISSUE/DRAIN is active.
- Asynchronous reset mid-operation: immediate return to IDLE, vl=0, any pending response dropped.

Optional Feature:
- Macro VSEQ_PERF_CNT_EN.
- Defined:
  - A 32-bit busy counter increments every cycle the state is ISSUE or DRAIN; it saturates at 32'hFFFF_FFFF.
  - funct=7 returns the count in the response and clears the counter when the response handshake completes.
- Undefined: no counter; funct=7 is illegal and returns 32'hFFFF_FFFF.

Decomposition:
- Package vseq_pkg holds:
  - funct codes: VSETVLI=0, VLOAD=1, VADDI=2, VACC=3, VMUL=4, VBACC=5, VPERF=7.
  - state enum {IDLE, ISSUE, DRAIN, RESP}.
  - ILLEGAL_RSP=32'hFFFF_FFFF.
- Single module. Element and drain counters are inline; no sub-module is warranted.

Test Plan:
- vsetvli with inputs_0=4 -> rsp_valid in cycle 1, payload=4, vl=4. Repeat with inputs_0=100 -> payload=16, vl=16.
- vl=4, DP_LAT=2, vadd (funct 2), rsp_ready held high:
  - dp_elem_valid in cycles 1-4 with idx 0,1,2,3; dp_last only in cycle 4.
  - rsp_valid in cycle 7 with payload = dp_result sampled at the cycle-6 edge.
- vl=0 then vmul -> payload 0 in cycle 1, dp_elem_valid never asserted. funct=6 -> payload 32'hFFFF_FFFF.
- Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid and payload stable throughout, cmd_ready=0, a cmd_valid presented meanwhile is not accepted; accepted in the first IDLE cycle after the handshake.
- reset_n pulsed low during ISSUE at idx=2 -> outputs immediately at reset values, vl=0, no response produced.
- With VSEQ_PERF_CNT_EN: vl=4 vacc (6 busy cycles) then funct=7 -> payload 6; a second funct=7 -> payload 0.

Source files
------------

// File: rtl/vector_seq_ctrl_pkg.sv
// Shared funct codes, FSM state encoding and constants for the vector command sequencer.
package vseq_pkg;

   typedef enum logic [2:0] {
      VSETVLI = 3'd0,
      VLOAD   = 3'd1,
      VADDI   = 3'd2,
      VACC    = 3'd3,
      VMUL    = 3'd4,
      VBACC   = 3'd5,
      VPERF   = 3'd7
   } funct_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam logic [31:0] ILLEGAL_RSP = 32'hFFFF_FFFF;

endpackage

// File: rtl/vector_seq_ctrl_if.sv
// CFU command/response bus; master is the CPU side, slave is the sequencer.
interface vector_seq_ctrl_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_payload_function_id;
   logic [31:0] cmd_payload_inputs_0;
   logic [31:0] cmd_payload_inputs_1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_payload_outputs_0;

   modport master (
      output cmd_valid,
      output cmd_payload_function_id,
      output cmd_payload_inputs_0,
      output cmd_payload_inputs_1,
      input  cmd_ready,
      input  rsp_valid,
      input  rsp_payload_outputs_0,
      output rsp_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_payload_function_id,
      input  cmd_payload_inputs_0,
      input  cmd_payload_inputs_1,
      output cmd_ready,
      output rsp_valid,
      output rsp_payload_outputs_0,
      input  rsp_ready
   );

endinterface

// File: rtl/vector_seq_ctrl.sv
// CFU command sequencer: holds vl, issues per-element strobes, drains the datapath, returns one response.
// Optional busy-cycle counter read by funct 7 when VSEQ_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | ready for a command
// ISSUE | one element strobe per cycle, idx 0..vl-1
// DRAIN | wait DP_LAT cycles for the datapath pipeline
// RESP  | response held until rsp_ready
module vector_seq_ctrl
   import vseq_pkg::*;
#(
   parameter int MAX_VL = 16,
   parameter int IDX_W  = 4,
   parameter int DP_LAT = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   vector_seq_ctrl_if.slave cfu,
   output logic [2:0]       dp_funct,
   output logic [4:0]       dp_vd,
   output logic [4:0]       dp_vs1,
   output logic [4:0]       dp_vs2,
   output logic [7:0]       dp_imm,
   output logic             dp_elem_valid,
   output logic [IDX_W-1:0] dp_elem_idx,
   output logic             dp_last,
   input  logic [31:0]      dp_result,
   output logic [IDX_W:0]   vl
);

   localparam int               DRW       = $clog2(DP_LAT + 1);
   localparam logic [DRW-1:0]   DRAIN_LD  = DRW'(DP_LAT);
   localparam logic [DRW-1:0]   DRAIN_ONE = DRW'(1);
   localparam logic [31:0]      MAX_VL_W  = 32'(MAX_VL);
   localparam logic [IDX_W:0]   MAX_VL_V  = (IDX_W+1)'(MAX_VL);
   localparam logic [IDX_W:0]   VL_ONE    = (IDX_W+1)'(1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

   state_e           state_q, state_d;
   logic [2:0]       funct_q, funct_d;
   logic [4:0]       vd_q, vd_d;
   logic [4:0]       vs1_q, vs1_d;
   logic [4:0]       vs2_q, vs2_d;
   logic [7:0]       imm_q, imm_d;
   logic [IDX_W:0]   vl_q, vl_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [DRW-1:0]   drain_q, drain_d;
   logic [31:0]      rsp_q, rsp_d;

   logic [2:0]       cmd_funct;
   logic [IDX_W:0]   vl_clamp;
   logic             last_elem;
   logic             rsp_done;
   logic             unused_bits;

   assign cmd_funct   = cfu.cmd_payload_function_id[2:0];
   // Full 32-bit compare so large lengths clamp instead of wrapping.
   assign vl_clamp    = (cfu.cmd_payload_inputs_0 > MAX_VL_W) ? MAX_VL_V
                                                              : cfu.cmd_payload_inputs_0[IDX_W:0];
   assign last_elem   = ({1'b0, idx_q} == (vl_q - VL_ONE));
   assign rsp_done    = (state_q == RESP) && cfu.rsp_ready;
   assign unused_bits = ^{cfu.cmd_payload_function_id[9:8], cfu.cmd_payload_inputs_1[31:5]};

`ifdef VSEQ_PERF_CNT_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_q <= '0;
      end else if (rsp_done && (funct_q == VPERF)) begin
         perf_q <= '0;
      end else if (((state_q == ISSUE) || (state_q == DRAIN)) && (perf_q != 32'hFFFF_FFFF)) begin
         perf_q <= perf_q + 32'd1;
      end
   end
`else
   logic unused_perf;
   assign unused_perf = rsp_done;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      funct_d = funct_q;
      vd_d    = vd_q;
      vs1_d   = vs1_q;
      vs2_d   = vs2_q;
      imm_d   = imm_q;
      vl_d    = vl_q;
      idx_d   = idx_q;
      drain_d = drain_q;
      rsp_d   = rsp_q;
      unique case (state_q)
         IDLE: begin
            if (cfu.cmd_valid) begin
               funct_d = cmd_funct;
               vd_d    = cfu.cmd_payload_function_id[7:3];
               vs1_d   = cfu.cmd_payload_inputs_0[4:0];
               vs2_d   = cfu.cmd_payload_inputs_1[4:0];
               imm_d   = cfu.cmd_payload_inputs_0[7:0];
               case (cmd_funct)
                  VSETVLI: begin
                     vl_d    = vl_clamp;
                     rsp_d   = 32'(vl_clamp);
                     state_d = RESP;
                  end
                  VLOAD, VADDI, VACC, VMUL, VBACC: begin
                     if (vl_q == '0) begin
                        rsp_d   = '0;
                        state_d = RESP;
                     end else begin
                        idx_d   = '0;
                        state_d = ISSUE;
                     end
                  end
                  VPERF: begin
`ifdef VSEQ_PERF_CNT_EN
                     rsp_d   = perf_q;
`else
                     rsp_d   = ILLEGAL_RSP;
`endif
                     state_d = RESP;
                  end
                  default: begin
                     rsp_d   = ILLEGAL_RSP;
                     state_d = RESP;
                  end
               endcase
            end
         end
         ISSUE: begin
            if (last_elem) begin
               drain_d = DRAIN_LD;
               state_d = DRAIN;
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end
         DRAIN: begin
            drain_d = drain_q - DRAIN_ONE;
            if (drain_q == DRAIN_ONE) begin
               rsp_d   = dp_result;
               state_d = RESP;
            end
         end
         RESP: begin
            if (cfu.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         funct_q <= '0;
         vd_q    <= '0;
         vs1_q   <= '0;
         vs2_q   <= '0;
         imm_q   <= '0;
         vl_q    <= '0;
         idx_q   <= '0;
         drain_q <= '0;
         rsp_q   <= '0;
      end else begin
         funct_q <= funct_d;
         vd_q    <= vd_d;
         vs1_q   <= vs1_d;
         vs2_q   <= vs2_d;
         imm_q   <= imm_d;
         vl_q    <= vl_d;
         idx_q   <= idx_d;
         drain_q <= drain_d;
         rsp_q   <= rsp_d;
      end
   end

   always_comb begin
      cfu.cmd_ready             = (state_q == IDLE);
      cfu.rsp_valid             = (state_q == RESP);
      cfu.rsp_payload_outputs_0 = rsp_q;
      dp_elem_valid             = (state_q == ISSUE);
      dp_last                   = (state_q == ISSUE) && last_elem;
      dp_elem_idx               = idx_q;
      dp_funct                  = funct_q;
      dp_vd                     = vd_q;
      dp_vs1                    = vs1_q;
      dp_vs2                    = vs2_q;
      dp_imm                    = imm_q;
      vl                        = vl_q;
   end

endmodule
